// File: rtl/qdot_seq_if.sv
// Operand/result handshake bundle for qdot_seq, including the operand and
// product paths to the shared external combinational qmult.
interface qdot_seq_if #(
  parameter int N     = 32,
  parameter int CNT_W = 4
);
  logic             i_start;
  logic [CNT_W-1:0] i_len;
  logic             i_op_valid;
  logic [N-1:0]     i_a;
  logic [N-1:0]     i_b;
  logic             o_op_ready;
  logic [N-1:0]     o_mul_multiplicand;
  logic [N-1:0]     o_mul_multiplier;
  logic [2*N-1:0]   i_mul_result;
  logic [N-1:0]     o_result;
  logic             o_valid;
  logic             i_result_ready;
  logic             o_busy;
  logic             o_ovr;

  modport slave (
    input  i_start, i_len, i_op_valid, i_a, i_b, i_mul_result, i_result_ready,
    output o_op_ready, o_mul_multiplicand, o_mul_multiplier, o_result, o_valid,
    output o_busy, o_ovr
  );

  modport master (
    output i_start, i_len, i_op_valid, i_a, i_b, i_mul_result, i_result_ready,
    input  o_op_ready, o_mul_multiplicand, o_mul_multiplier, o_result, o_valid,
    input  o_busy, o_ovr
  );
endinterface

// File: rtl/qdot_seq.sv
// Sequential sign-magnitude Q-format dot product of up to K_MAX pairs, one
// pair every two cycles through a shared external magnitude multiplier.
module qdot_seq #(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int K_MAX = 9,
  parameter int CNT_W = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  qdot_seq_if.slave bus
);

  localparam int AW = 2*N - 1 + CNT_W;
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(K_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]    MAG_MAX = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MUL   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    acc_q;
  logic             sign_q;
  logic [N-1:0]     mul_a_q, mul_b_q;
  logic [N-1:0]     result_q;
  logic             ovr_q;
  logic             op_ready_q, op_ready_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic [AW-1:0]    prod_s;
  logic [AW-1:0]    acc_abs_s;
  logic [AW-1:0]    mag_s;
  logic [N-2:0]     res_mag_s;
  logic             res_sign_s;
  logic             sat_s;

  assign prod_s = {{(AW-2*N){1'b0}}, bus.i_mul_result};

  // Next-state logic; the status flags are registered from the next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_len == {CNT_W{1'b0}}) begin
            state_d = S_NORM;
          end else if (bus.i_len > LEN_MAX) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (bus.i_op_valid) begin
          state_d = S_MUL;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MUL: begin
        if ((cnt_q + CNT_ONE) < len_q) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: state_d = S_DONE;
      S_DONE: begin
        if (bus.i_result_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    op_ready_d = (state_d == S_FETCH);
    busy_d     = (state_d != S_IDLE);
    valid_d    = (state_d == S_DONE);
  end

  // Normalisation: truncate |acc| toward zero, saturate, never emit -0.
  always_comb begin
    acc_abs_s  = acc_q;
    res_mag_s  = {(N-1){1'b0}};
    sat_s      = 1'b0;
    if (acc_q[AW-1]) begin
      acc_abs_s = -acc_q;
    end else begin
      acc_abs_s = acc_q;
    end
    mag_s = acc_abs_s >> Q;
    if (mag_s > MAG_MAX) begin
      res_mag_s = {(N-1){1'b1}};
      sat_s     = 1'b1;
    end else begin
      res_mag_s = mag_s[N-2:0];
      sat_s     = 1'b0;
    end
    res_sign_s = acc_q[AW-1] & (res_mag_s != {(N-1){1'b0}});
  end

  // State, flags and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      len_q      <= {CNT_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      acc_q      <= {AW{1'b0}};
      sign_q     <= 1'b0;
      mul_a_q    <= {N{1'b0}};
      mul_b_q    <= {N{1'b0}};
      result_q   <= {N{1'b0}};
      ovr_q      <= 1'b0;
      op_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_ready_q <= op_ready_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            len_q    <= bus.i_len;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {AW{1'b0}};
            result_q <= {N{1'b0}};
            ovr_q    <= (bus.i_len > LEN_MAX);
          end
        end
        S_FETCH: begin
          if (bus.i_op_valid) begin
            mul_a_q <= bus.i_a;
            mul_b_q <= bus.i_b;
            sign_q  <= bus.i_a[N-1] ^ bus.i_b[N-1];
          end
        end
        S_MUL: begin
          // The accumulator is wide enough for K_MAX full-scale products.
          if (sign_q) begin
            acc_q <= acc_q - prod_s;
          end else begin
            acc_q <= acc_q + prod_s;
          end
          cnt_q <= cnt_q + CNT_ONE;
        end
        S_NORM: begin
          result_q <= {res_sign_s, res_mag_s};
          ovr_q    <= sat_s;
        end
        S_DONE: begin
          result_q <= result_q;
        end
        default: begin
          result_q <= result_q;
        end
      endcase
    end
  end

  assign bus.o_op_ready         = op_ready_q;
  assign bus.o_busy             = busy_q;
  assign bus.o_valid            = valid_q;
  assign bus.o_result           = result_q;
  assign bus.o_ovr              = ovr_q;
  assign bus.o_mul_multiplicand = mul_a_q;
  assign bus.o_mul_multiplier   = mul_b_q;

endmodule
